// File: rtl/rvv_xrf_wb_arbiter_pkg.sv
// Shared retire-to-scalar-regfile types for the RVV backend writeback path.
// Holds the per-slot writeback record and the retire slot count.
// Widths here set the default widths of the writeback arbiter.
`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif

package rvv_xrf_wb_arbiter_pkg;

  localparam int NUM_RT_UOP = `NUM_RT_UOP;
  localparam int XRF_ADDR_W = 5;
  localparam int XRF_DATA_W = 32;

  // One scalar-regfile writeback: destination index and data.
  typedef struct packed {
    logic [XRF_ADDR_W-1:0] rt_index;
    logic [XRF_DATA_W-1:0] rt_data;
  } RT2XRF_t;

endpackage

// File: rtl/rvv_multi_push_fifo.sv
// Purpose: circular FIFO taking up to NUM_W compacted writes per cycle, one read.
// Latency: a write is visible at the head no earlier than the next cycle.
// Backpressure: none internally; the caller must not push beyond DEPTH-count.
module rvv_multi_push_fifo
  import rvv_xrf_wb_arbiter_pkg::*;
#(
  parameter int NUM_W = NUM_RT_UOP,
  parameter int DEPTH = 8,
  parameter int W     = $bits(RT2XRF_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_W-1:0]   push_mask_i,
  input  logic [NUM_W*W-1:0] push_dat_i,
  input  logic               pop_i,
  output logic [W-1:0]       head_dat_o,
  output logic               head_vld_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_push;
  logic             pop;

  assign head_vld_o = (count_q != '0);
  assign pop        = pop_i && head_vld_o;
  // Head is masked while empty so stale entries never leak onto the bus.
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  // Number of writes this cycle; lanes are compacted so this is also the pointer step.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NUM_W; k++) begin
      n_push = n_push + CNT_W'(push_mask_i[k]);
    end
  end

  // Pointer and occupancy next-state; pointers wrap modulo DEPTH by width.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + n_push - CNT_W'(pop);
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: lane k lands at wr_ptr+k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_W; k++) begin
        if (push_mask_i[k]) begin
          mem_q[wr_ptr_q + PTR_W'(k)] <= push_dat_i[k*W +: W];
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_q} + {1'b0, n_push}) <= (CNT_W+1)'(DEPTH));
  a_no_empty_pop : assert property (@(posedge clk) disable iff (rst)
    pop_i |-> (count_q != '0));
`endif

endmodule

// File: rtl/rvv_xrf_wb_arbiter.sv
// Purpose: merge per-slot retire scalar writebacks into the single async_rd port, in program order.
// Latency: one cycle minimum from acceptance to out_valid; no bypass.
// Backpressure: in_ready from registered occupancy only; refusal is always a suffix of the slots.
module rvv_xrf_wb_arbiter
  import rvv_xrf_wb_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_RT_UOP,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = XRF_ADDR_W,
  parameter int DATA_W    = XRF_DATA_W,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            count,
  output logic                        idle
);

  localparam int W      = $bits(RT2XRF_t);
  localparam int LANE_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if ((ADDR_W != XRF_ADDR_W) || (DATA_W != XRF_DATA_W) || (DEPTH < NUM_PORTS)) begin : g_bad_cfg
    $error("rvv_xrf_wb_arbiter: widths must match RT2XRF_t and DEPTH must be >= NUM_PORTS");
  end

  RT2XRF_t              req   [NUM_PORTS];
  RT2XRF_t              lane  [NUM_PORTS];
  logic [CNT_W-1:0]     need  [NUM_PORTS];
  logic [CNT_W-1:0]     free_slots;
  logic [CNT_W-1:0]     run;
  logic [LANE_W-1:0]    off;
  logic [NUM_PORTS-1:0] push_mask;
  logic [NUM_PORTS*W-1:0] push_dat;
  logic [W-1:0]         head_dat;
  RT2XRF_t              head;
  logic                 head_vld;

  // Unpack the flattened slot buses into writeback records.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i].rt_index = in_addr[i*ADDR_W +: ADDR_W];
      req[i].rt_data  = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Prefix count of real (non-x0) requests; a slot is ready when all of them up to it fit.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count;
    run        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && (req[i].rt_index != '0)) begin
        run = run + CNT_W'(1);
      end
      need[i]     = run;
      in_ready[i] = (free_slots >= run);
    end
  end

  // Compact accepted non-x0 slots onto consecutive write lanes; x0 slots are dropped here.
  always_comb begin
    push_mask = '0;
    off       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      lane[k] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && in_ready[i] && (req[i].rt_index != '0)) begin
        off            = LANE_W'(need[i] - CNT_W'(1));
        push_mask[off] = 1'b1;
        lane[off]      = req[i];
      end
    end
  end

  // Flatten the lanes for the FIFO write port.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      push_dat[k*W +: W] = lane[k];
    end
  end

  rvv_multi_push_fifo #(
    .NUM_W (NUM_PORTS),
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_mask_i (push_mask),
    .push_dat_i  (push_dat),
    .pop_i       (head_vld && out_ready),
    .head_dat_o  (head_dat),
    .head_vld_o  (head_vld),
    .count_o     (count)
  );

  assign head      = head_dat;
  assign out_valid = head_vld;
  assign out_addr  = head.rt_index;
  assign out_data  = head.rt_data;
  assign idle      = (count == '0) && (in_valid == '0);

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_hold_chk
    a_hold : assert property (@(posedge clk) disable iff (rst)
      (in_valid[g] && !in_ready[g]) |=> in_valid[g]);
  end
`endif

endmodule

// File: tb/tb_rvv_xrf_wb_arbiter.sv
// Self-checking bench for rvv_xrf_wb_arbiter: directed scenarios plus random traffic.
// Expected values come from a queue model of the writeback stream.
module tb_rvv_xrf_wb_arbiter;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_valid;
  logic [NP*AW-1:0] in_addr;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic [AW-1:0]    out_addr;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             idle;

  always #5 clk = ~clk;

  rvv_xrf_wb_arbiter #(.NUM_PORTS(NP), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .idle      (idle)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Model: the ordered stream of writebacks waiting for the regfile.
  ent_t          q[$];
  // Upstream requests held per slot until accepted.
  logic [NP-1:0] pv;
  logic [AW-1:0] pa [NP];
  logic [DW-1:0] pd [NP];

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic req(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[s] = 1'b1;
    pa[s] = a;
    pd[s] = d;
  endtask

  // One clock: drive held requests, check all outputs against the model, then advance it.
  task automatic step();
    int            free_n;
    int            real_n;
    logic [NP-1:0] exp_rdy;
    in_valid = pv;
    for (int i = 0; i < NP; i++) begin
      in_addr[i*AW +: AW] = pa[i];
      in_data[i*DW +: DW] = pd[i];
    end
    @(negedge clk);
    free_n = DEPTH - q.size();
    real_n = 0;
    for (int i = 0; i < NP; i++) begin
      if (pv[i] && pa[i] != 0) real_n++;
      exp_rdy[i] = (free_n >= real_n);
    end
    chk("in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("count",     64'(count),     64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_addr",  64'(out_addr),  (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    chk("out_data",  64'(out_data),  (q.size() != 0) ? 64'(q[0].d) : 64'd0);
    chk("idle",      64'(idle),      64'((q.size() == 0) && (pv == '0)));
    @(posedge clk);
    if (q.size() != 0 && out_ready) begin
      void'(q.pop_front());
      n_pop++;
    end
    for (int i = 0; i < NP; i++) begin
      if (pv[i] && exp_rdy[i]) begin
        if (pa[i] != 0) q.push_back('{a: pa[i], d: pd[i]});
        pv[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || pv != '0) && guard < 60) begin
      step();
      guard++;
    end
    chk("drain_done", 64'(q.size() + int'(pv != '0)), 64'd0);
  endtask

  initial begin
    int pops0;
    int guard;
    pv = '0;
    for (int i = 0; i < NP; i++) begin
      pa[i] = '0;
      pd[i] = '0;
    end
    in_valid  = '0;
    in_addr   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #3;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ordering: four slots in one cycle leave in slot order.
    out_ready = 1'b1;
    req(0, 5'd1, 32'hD000_0000);
    req(1, 5'd2, 32'hD111_1111);
    req(2, 5'd3, 32'hD222_2222);
    req(3, 5'd4, 32'hD333_3333);
    step();
    for (int c = 0; c < 5; c++) step();

    // x0 filter: only register 7 is stored.
    req(0, 5'd0, 32'hAAAA_0000);
    req(1, 5'd7, 32'h7777_7777);
    req(2, 5'd0, 32'hAAAA_2222);
    step();
    for (int c = 0; c < 3; c++) step();

    // Fill to 6, then partial accept of a 4-slot burst, then full.
    out_ready = 1'b0;
    for (int i = 0; i < NP; i++) req(i, AW'(8 + i), DW'(32'h100 + i));
    step();
    req(0, 5'd12, 32'h200);
    req(1, 5'd13, 32'h201);
    step();
    for (int i = 0; i < NP; i++) req(i, AW'(16 + i), DW'(32'h300 + i));
    step();
    step();
    // Full with pop: no push that cycle; afterwards one push per pop.
    out_ready = 1'b1;
    step();
    step();
    step();
    drain();

    // Wrap-around: 20 single-slot writes with alternating out_ready.
    pops0 = n_pop;
    for (int n = 0; n < 20; n++) begin
      req(0, AW'($urandom_range(1, 31)), $urandom);
      guard = 0;
      while (pv[0] && guard < 10) begin
        out_ready = ~out_ready;
        step();
        guard++;
      end
      chk("wrap_accept", 64'(pv[0]), 64'd0);
    end
    drain();
    chk("wrap_pops", 64'(n_pop - pops0), 64'd20);

    // Asynchronous reset with five entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < NP; i++) req(i, AW'(20 + i), $urandom);
    step();
    req(0, 5'd30, 32'hBEEF);
    step();
    step();
    chk("pre_rst_count", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'hF);
    chk("arst_out_addr",  64'(out_addr),  64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();

    // Random traffic with phases of heavy and light drain.
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int s = 0; s < NP; s++) begin
        if (!pv[s] && $urandom_range(0, 2) == 0) begin
          req(s, ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 31)), $urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < (((cyc / 50) % 2 == 0) ? 25 : 85));
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
